pulse_identifier_sequencer: RTL and testbench

- Controller that sequences one pulse_identifier instance: detects its result, snapshots the 8 per-sensor iteration values and the polynomial, then serialises them as a byte frame to the UART/host link.
- Acknowledges the pulse_identifier through its reset input, re-arming it for the next sweep.
- Guards link stalls and stuck acknowledges with a timeout watchdog.
- Sits between pulse_identifier and the byte-stream transmitter.

---
 rtl/pulse_identifier_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_pulse_identifier_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_identifier_sequencer.sv
// pulse_identifier_sequencer
//
// Sequences one pulse_identifier instance: waits for its ready flag, snapshots the
// polynomial and the eight per-sensor iteration values, serialises them as a byte
// frame towards the host link, then acknowledges the pulse_identifier through its
// reset input so it re-arms for the next sweep. A watchdog bounds both link stalls
// and a pulse_identifier that never drops ready after the acknowledge.
//
// Frame: A5, {7'b0,poly[16]}, poly[15:8], poly[7:0], mask,
//        {7'b0,it[16]}, it[15:8], it[7:0] for each hit sensor (ascending index),
//        checksum (XOR of all bytes after the header).
//
// Ports:
//   clk_72MHz          system clock
//   reset              synchronous, active-high reset
//   pid_ready          ready flag from pulse_identifier
//   pid_reset          acknowledge, drives the pulse_identifier reset input
//   polynomial         identified polynomial (17 bits)
//   iteration_0..7     per-sensor iteration (17 bits), 0 = sensor not hit
//   tx_data/tx_valid   frame byte stream, tx_ready accepts a byte
//   frame_count        completed frames, wraps
//   timeout_count      watchdog events, saturates at 255
//   busy               high whenever the controller is not idle
module pulse_identifier_sequencer #(
    parameter int unsigned TIMEOUT_TICKS = 72000
) (
    input  logic        clk_72MHz,
    input  logic        reset,
    input  logic        pid_ready,
    output logic        pid_reset,
    input  logic [16:0] polynomial,
    input  logic [16:0] iteration_0,
    input  logic [16:0] iteration_1,
    input  logic [16:0] iteration_2,
    input  logic [16:0] iteration_3,
    input  logic [16:0] iteration_4,
    input  logic [16:0] iteration_5,
    input  logic [16:0] iteration_6,
    input  logic [16:0] iteration_7,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] frame_count,
    output logic [7:0]  timeout_count,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StSend, StAck} state_e;
    // Names the byte currently presented on tx_data while in StSend.
    typedef enum logic [2:0] {
        FHdr, FPolyHi, FPolyMid, FPolyLo, FMask, FSensor, FChk
    } field_e;

    localparam logic [19:0] TimeoutLim = 20'(TIMEOUT_TICKS);

    state_e      state_q;
    field_e      field_q;
    logic        armed_q;
    logic [16:0] snap_poly_q;
    logic [16:0] snap_it_q [8];
    logic [7:0]  mask_q;
    logic [2:0]  sensor_q;
    logic [1:0]  sub_q;      // 0: bit 16, 1: bits 15:8, 2: bits 7:0
    logic [7:0]  chk_q;
    logic [19:0] wd_q;

    logic [16:0] it_in [8];
    logic [7:0]  mask_in;
    logic [7:0]  chk_upd;
    logic [3:0]  search_start;
    logic        nxt_found;
    logic [2:0]  nxt_idx;
    logic        wd_hit;

    assign it_in[0] = iteration_0;
    assign it_in[1] = iteration_1;
    assign it_in[2] = iteration_2;
    assign it_in[3] = iteration_3;
    assign it_in[4] = iteration_4;
    assign it_in[5] = iteration_5;
    assign it_in[6] = iteration_6;
    assign it_in[7] = iteration_7;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            mask_in[i] = |it_in[i];
        end
    end

    // Running checksum including the byte being accepted; the header is excluded.
    // Next hit sensor: lowest set mask bit at or above search_start.
    always_comb begin
        chk_upd      = (field_q == FHdr) ? 8'h00 : (chk_q ^ tx_data);
        search_start = (field_q == FMask) ? 4'd0 : ({1'b0, sensor_q} + 4'd1);
        nxt_found    = 1'b0;
        nxt_idx      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (4'(i) >= search_start)) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(i);
            end
        end
    end

    assign wd_hit = (wd_q + 20'd1) >= TimeoutLim;
    assign busy   = (state_q != StIdle);

    always_ff @(posedge clk_72MHz) begin
        if (reset) begin
            state_q       <= StIdle;
            field_q       <= FHdr;
            armed_q       <= 1'b1;
            snap_poly_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                snap_it_q[i] <= '0;
            end
            mask_q        <= '0;
            sensor_q      <= '0;
            sub_q         <= '0;
            chk_q         <= '0;
            wd_q          <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            pid_reset     <= 1'b0;
            frame_count   <= '0;
            timeout_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pid_ready && armed_q) begin
                        snap_poly_q <= polynomial;
                        for (int i = 0; i < 8; i++) begin
                            snap_it_q[i] <= it_in[i];
                        end
                        mask_q   <= mask_in;
                        armed_q  <= 1'b0;
                        field_q  <= FHdr;
                        sensor_q <= '0;
                        sub_q    <= '0;
                        chk_q    <= '0;
                        wd_q     <= '0;
                        tx_data  <= 8'hA5;
                        tx_valid <= 1'b1;
                        state_q  <= StSend;
                    end else if (!pid_ready) begin
                        armed_q <= 1'b1;
                    end
                end

                StSend: begin
                    if (tx_ready) begin
                        wd_q  <= '0;
                        chk_q <= chk_upd;
                        case (field_q)
                            FHdr: begin
                                tx_data <= {7'b0, snap_poly_q[16]};
                                field_q <= FPolyHi;
                            end
                            FPolyHi: begin
                                tx_data <= snap_poly_q[15:8];
                                field_q <= FPolyMid;
                            end
                            FPolyMid: begin
                                tx_data <= snap_poly_q[7:0];
                                field_q <= FPolyLo;
                            end
                            FPolyLo: begin
                                tx_data <= mask_q;
                                field_q <= FMask;
                            end
                            FMask, FSensor: begin
                                if (field_q == FSensor && sub_q == 2'd0) begin
                                    tx_data <= snap_it_q[sensor_q][15:8];
                                    sub_q   <= 2'd1;
                                end else if (field_q == FSensor && sub_q == 2'd1) begin
                                    tx_data <= snap_it_q[sensor_q][7:0];
                                    sub_q   <= 2'd2;
                                end else if (nxt_found) begin
                                    tx_data  <= {7'b0, snap_it_q[nxt_idx][16]};
                                    sensor_q <= nxt_idx;
                                    sub_q    <= 2'd0;
                                    field_q  <= FSensor;
                                end else begin
                                    tx_data <= chk_upd;
                                    field_q <= FChk;
                                end
                            end
                            default: begin
                                // Checksum accepted: frame complete.
                                tx_valid    <= 1'b0;
                                frame_count <= frame_count + 16'd1;
                                pid_reset   <= 1'b1;
                                wd_q        <= '0;
                                state_q     <= StAck;
                            end
                        endcase
                    end else if (wd_hit) begin
                        tx_valid  <= 1'b0;
                        pid_reset <= 1'b1;
                        wd_q      <= '0;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state_q <= StAck;
                    end else begin
                        wd_q <= wd_q + 20'd1;
                    end
                end

                StAck: begin
                    if (!pid_ready) begin
                        pid_reset <= 1'b0;
                        armed_q   <= 1'b1;
                        state_q   <= StIdle;
                    end else if (wd_hit) begin
                        // Leave disarmed so stale results are not re-captured.
                        pid_reset <= 1'b0;
                        armed_q   <= 1'b0;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                        state_q <= StIdle;
                    end else begin
                        wd_q <= wd_q + 20'd1;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_identifier_sequencer.sv
// Testbench for pulse_identifier_sequencer: table of whole-frame vectors plus
// hand-written sequences for link timeout, acknowledge timeout and mid-frame reset.
module tb_pulse_identifier_sequencer;

    logic        clk_72MHz = 1'b0;
    logic        reset;
    logic        pid_ready;
    logic        pid_reset;
    logic [16:0] poly_drv;
    logic [16:0] it_drv [8];
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] frame_count;
    logic [7:0]  timeout_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_timeouts = 0;

    always #5 clk_72MHz = ~clk_72MHz;

    pulse_identifier_sequencer #(
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk_72MHz    (clk_72MHz),
        .reset        (reset),
        .pid_ready    (pid_ready),
        .pid_reset    (pid_reset),
        .polynomial   (poly_drv),
        .iteration_0  (it_drv[0]),
        .iteration_1  (it_drv[1]),
        .iteration_2  (it_drv[2]),
        .iteration_3  (it_drv[3]),
        .iteration_4  (it_drv[4]),
        .iteration_5  (it_drv[5]),
        .iteration_6  (it_drv[6]),
        .iteration_7  (it_drv[7]),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .frame_count  (frame_count),
        .timeout_count(timeout_count),
        .busy         (busy)
    );

    typedef struct {
        logic [16:0]      poly;
        logic [7:0][16:0] its;
        bit               alt_ready;
        int               len;
        logic [239:0]     bytes;   // first byte in the most significant used position
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk_72MHz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_inputs(input int k);
        poly_drv = vecs[k].poly;
        for (int i = 0; i < 8; i++) begin
            it_drv[i] = vecs[k].its[i];
        end
    endtask

    // Runs the rest of a started frame at full rate and acknowledges it.
    task automatic drain_frame(input string tag);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (tx_valid && n < 60) begin
            step();
            n++;
        end
        tx_ready = 1'b0;
        check({tag, "_drained"}, 32'(tx_valid), 32'd0);
        exp_frames++;
        check({tag, "_frames"}, 32'(frame_count), 32'(exp_frames));
        pid_ready = 1'b0;
        step();
        check({tag, "_ack_rel"}, 32'(pid_reset), 32'd0);
    endtask

    task automatic run_frame(input int k);
        int         got;
        int         cyc;
        logic [7:0] held;
        logic       stalled;
        pid_ready = 1'b0;
        tx_ready  = 1'b0;
        load_inputs(k);
        step();
        pid_ready = 1'b1;
        step();
        check($sformatf("v%0d_valid_rise", k), 32'(tx_valid), 32'd1);
        // Inputs change during the frame; the snapshot must not follow them.
        poly_drv = ~poly_drv;
        for (int i = 0; i < 8; i++) begin
            it_drv[i] = ~it_drv[i];
        end
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (got < vecs[k].len && cyc < 200) begin
            if (stalled) begin
                check($sformatf("v%0d_hold_c%0d", k, cyc), {23'd0, tx_valid, tx_data},
                      {23'd0, 1'b1, held});
            end
            tx_ready = vecs[k].alt_ready ? (cyc % 2 == 0) : 1'b1;
            if (tx_valid && tx_ready) begin
                check($sformatf("v%0d_byte%0d", k, got), 32'(tx_data),
                      32'(vecs[k].bytes[8*(vecs[k].len-1-got) +: 8]));
                got++;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            step();
            cyc++;
        end
        tx_ready = 1'b0;
        check($sformatf("v%0d_count", k), 32'(got), 32'(vecs[k].len));
        if (!vecs[k].alt_ready) begin
            check($sformatf("v%0d_cycles", k), 32'(cyc), 32'(vecs[k].len));
        end
        check($sformatf("v%0d_valid_drop", k), 32'(tx_valid), 32'd0);
        check($sformatf("v%0d_pid_reset", k), 32'(pid_reset), 32'd1);
        exp_frames++;
        check($sformatf("v%0d_frames", k), 32'(frame_count), 32'(exp_frames));
        step();
        check($sformatf("v%0d_ack_hold", k), {30'd0, pid_reset, busy}, 32'd3);
        pid_ready = 1'b0;
        step();
        check($sformatf("v%0d_ack_rel", k), {30'd0, pid_reset, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0].poly = 17'h0D8F7;
        vecs[0].its = '0;
        vecs[0].its[0] = 17'h00123;
        vecs[0].its[5] = 17'h1ABCD;
        vecs[0].alt_ready = 1'b0;
        vecs[0].len = 12;
        vecs[0].bytes = {8'hA5, 8'h00, 8'hD8, 8'hF7, 8'h21, 8'h00, 8'h01, 8'h23,
                         8'h01, 8'hAB, 8'hCD, 8'h4B};
        vecs[1] = vecs[0];
        vecs[1].alt_ready = 1'b1;
        vecs[2].poly = 17'h10001;
        vecs[2].its = '0;
        vecs[2].alt_ready = 1'b0;
        vecs[2].len = 6;
        vecs[2].bytes = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
        vecs[3].poly = 17'h00000;
        vecs[3].its = '0;
        vecs[3].its[7] = 17'h1FFFF;
        vecs[3].alt_ready = 1'b0;
        vecs[3].len = 9;
        vecs[3].bytes = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'hFF, 8'hFF, 8'h81};
        vecs[4].poly = 17'h1FFFF;
        vecs[4].its = '0;
        vecs[4].its[1] = 17'h00001;
        vecs[4].its[2] = 17'h10000;
        vecs[4].alt_ready = 1'b1;
        vecs[4].len = 12;
        vecs[4].bytes = {8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h06, 8'h00, 8'h00, 8'h01,
                         8'h01, 8'h00, 8'h00, 8'h07};

        reset     = 1'b1;
        pid_ready = 1'b0;
        tx_ready  = 1'b0;
        poly_drv  = '0;
        for (int i = 0; i < 8; i++) begin
            it_drv[i] = '0;
        end
        repeat (3) step();
        reset = 1'b0;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pid_reset", 32'(pid_reset), 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_timeouts", 32'(timeout_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 5; k++) begin
            run_frame(k);
        end

        // Link stall after the header: abort on the 16th stalled cycle.
        load_inputs(0);
        step();
        pid_ready = 1'b1;
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        repeat (15) step();
        check("stall15_valid", 32'(tx_valid), 32'd1);
        check("stall15_data", 32'(tx_data), 32'h00);
        step();
        exp_timeouts++;
        check("tx_to_valid", 32'(tx_valid), 32'd0);
        check("tx_to_timeouts", 32'(timeout_count), 32'(exp_timeouts));
        check("tx_to_frames", 32'(frame_count), 32'(exp_frames));
        check("tx_to_pid_reset", 32'(pid_reset), 32'd1);
        pid_ready = 1'b0;
        step();
        check("tx_to_release", {30'd0, pid_reset, busy}, 32'd0);

        // pid_ready stuck high during the acknowledge.
        load_inputs(2);
        pid_ready = 1'b1;
        step();
        tx_ready = 1'b1;
        repeat (6) step();
        tx_ready = 1'b0;
        exp_frames++;
        check("ackto_in_ack", {30'd0, tx_valid, pid_reset}, 32'd1);
        check("ackto_frames", 32'(frame_count), 32'(exp_frames));
        repeat (15) step();
        check("ackto_wait", 32'(pid_reset), 32'd1);
        step();
        exp_timeouts++;
        check("ackto_release", {30'd0, pid_reset, busy}, 32'd0);
        check("ackto_timeouts", 32'(timeout_count), 32'(exp_timeouts));
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("ackto_no_recap%0d", i), {30'd0, tx_valid, busy}, 32'd0);
        end
        pid_ready = 1'b0;
        step();
        pid_ready = 1'b1;
        step();
        check("ackto_rearm", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        drain_frame("ackto");

        // Reset while the mask byte is pending.
        load_inputs(0);
        pid_ready = 1'b1;
        step();
        tx_ready = 1'b1;
        repeat (4) step();
        tx_ready = 1'b0;
        check("rstmid_pending", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h21});
        reset     = 1'b1;
        pid_ready = 1'b0;
        step();
        reset = 1'b0;
        exp_frames   = 0;
        exp_timeouts = 0;
        check("rstmid_valid", 32'(tx_valid), 32'd0);
        check("rstmid_pid_reset", 32'(pid_reset), 32'd0);
        check("rstmid_counters", {8'd0, frame_count, timeout_count}, 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        step();
        pid_ready = 1'b1;
        step();
        check("rstmid_fresh", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        drain_frame("rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
